// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed UART command decoder with checksum, byte-gap abort and link-loss failsafe
//
// Frame format: HEADER, CMD, LEN, LEN payload bytes, CSUM where CSUM = CMD ^ LEN ^ payload bytes.
// A checksum-correct frame produces a one-cycle cmd_valid together with updated
// cmd_code/cmd_arg/action_out. Discarded frames produce a one-cycle frame_err.
//
// Ports:
//   clk, rst_n          50 MHz clock, asynchronous active-low reset
//   rx_valid, rx_byte   byte strobe and data from the UART receiver
//   cmd_valid           one-cycle strobe: new validated frame
//   cmd_code, cmd_arg   command byte and right-justified payload of the last valid frame
//   action_out          last valid cmd_code, or FAILSAFE_CMD while the link is lost
//   link_lost           no valid frame for LINK_TIMEOUT_CYC cycles
//   frame_err           one-cycle strobe: frame discarded (length, checksum or byte gap)
//   err_count           (only with CMD_ERR_STATS_EN) saturating frame_err counter,
//                       cleared by a valid frame with cmd_code 8'hFF
//
// Optional feature macro: CMD_ERR_STATS_EN

module uart_cmd_parser #(
    parameter logic [7:0] HEADER           = 8'hAA,
    parameter int         MAX_LEN          = 4,
    parameter int         BYTE_TIMEOUT_CYC = 50000,
    parameter int         LINK_TIMEOUT_CYC = 25000000,
    parameter logic [7:0] FAILSAFE_CMD     = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
`ifdef CMD_ERR_STATS_EN
    output logic [7:0]  err_count,
`endif
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [31:0] cmd_arg,
    output logic [7:0]  action_out,
    output logic        link_lost,
    output logic        frame_err
);

    localparam int         GAP_W     = $clog2(BYTE_TIMEOUT_CYC + 1);
    localparam int         LINK_W    = $clog2(LINK_TIMEOUT_CYC + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(BYTE_TIMEOUT_CYC - 1);
    localparam logic [LINK_W-1:0] LINK_MAX = LINK_W'(LINK_TIMEOUT_CYC);

    typedef enum logic [2:0] {WAIT_HDR, GET_CMD, GET_LEN, GET_PAY, GET_CSUM} state_t;

    state_t            state, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        xor_q, xor_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        idx_q, idx_d;
    logic [31:0]       arg_q, arg_d;
    logic [GAP_W-1:0]  gap_q;
    logic [LINK_W-1:0] link_q;
    logic              gap_timeout;
    logic              accept;
    logic              reject;

    // gap_q counts cycles since the last byte; the timeout edge is the
    // BYTE_TIMEOUT_CYC-th one, and a byte arriving on that same edge is dropped.
    assign gap_timeout = (state != WAIT_HDR) && (gap_q == GAP_LAST);

    always_comb begin
        state_d = state;
        cmd_d   = cmd_q;
        xor_d   = xor_q;
        len_d   = len_q;
        idx_d   = idx_q;
        arg_d   = arg_q;
        accept  = 1'b0;
        reject  = 1'b0;
        if (gap_timeout) begin
            reject  = 1'b1;
            state_d = WAIT_HDR;
        end else if (rx_valid) begin
            case (state)
                WAIT_HDR: begin
                    if (rx_byte == HEADER) state_d = GET_CMD;
                end
                GET_CMD: begin
                    cmd_d   = rx_byte;
                    xor_d   = rx_byte;
                    state_d = GET_LEN;
                end
                GET_LEN: begin
                    xor_d = xor_q ^ rx_byte;
                    arg_d = '0;   // also gives cmd_arg = 0 for zero-length frames
                    idx_d = '0;
                    len_d = rx_byte[2:0];
                    if (rx_byte > MAX_LEN_B) begin
                        reject  = 1'b1;
                        state_d = WAIT_HDR;
                    end else if (rx_byte == 8'd0) begin
                        state_d = GET_CSUM;
                    end else begin
                        state_d = GET_PAY;
                    end
                end
                GET_PAY: begin
                    arg_d = {arg_q[23:0], rx_byte};
                    xor_d = xor_q ^ rx_byte;
                    idx_d = idx_q + 3'd1;
                    if (idx_q + 3'd1 == len_q) state_d = GET_CSUM;
                end
                GET_CSUM: begin
                    if (rx_byte == xor_q) accept = 1'b1;
                    else                  reject = 1'b1;
                    state_d = WAIT_HDR;
                end
                default: state_d = WAIT_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_HDR;
            cmd_q <= '0;
            xor_q <= '0;
            len_q <= '0;
            idx_q <= '0;
            arg_q <= '0;
            gap_q <= '0;
        end else begin
            state <= state_d;
            cmd_q <= cmd_d;
            xor_q <= xor_d;
            len_q <= len_d;
            idx_q <= idx_d;
            arg_q <= arg_d;
            if (rx_valid || gap_timeout || state == WAIT_HDR) gap_q <= '0;
            else                                              gap_q <= gap_q + GAP_W'(1);
        end
    end

    // Published outputs and link supervision. A frame accepted on the edge the
    // link counter would expire takes priority, so the link never drops then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid  <= 1'b0;
            frame_err  <= 1'b0;
            cmd_code   <= '0;
            cmd_arg    <= '0;
            action_out <= '0;
            link_lost  <= 1'b0;
            link_q     <= '0;
        end else begin
            cmd_valid <= accept;
            frame_err <= reject;
            if (accept) begin
                cmd_code   <= cmd_q;
                cmd_arg    <= arg_q;
                action_out <= cmd_q;
                link_lost  <= 1'b0;
                link_q     <= '0;
            end else if (link_q != LINK_MAX) begin
                link_q <= link_q + LINK_W'(1);
                if (link_q == LINK_MAX - LINK_W'(1)) begin
                    link_lost  <= 1'b1;
                    action_out <= FAILSAFE_CMD;
                end
            end
        end
    end

`ifdef CMD_ERR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && cmd_q == 8'hFF) begin
            err_count <= '0;
        end else if (reject && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
